// File: rtl/m_ext_pkg.sv
`default_nettype none
// ============================================================================
// m_ext_pkg : op codes, lane state encoding and op-class decode helpers
// Rev 1.0
// ============================================================================
package m_ext_pkg;

  localparam int OP_W = 6;
  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_MUL    = 6'd0;
  localparam opcode_t OP_MULH   = 6'd1;
  localparam opcode_t OP_MULHSU = 6'd2;
  localparam opcode_t OP_MULHU  = 6'd3;
  localparam opcode_t OP_DIV    = 6'd4;
  localparam opcode_t OP_DIVU   = 6'd5;
  localparam opcode_t OP_REM    = 6'd6;
  localparam opcode_t OP_REMU   = 6'd7;
  localparam opcode_t OP_MULW   = 6'd8;
  localparam opcode_t OP_DIVW   = 6'd9;
  localparam opcode_t OP_DIVUW  = 6'd10;
  localparam opcode_t OP_REMW   = 6'd11;
  localparam opcode_t OP_REMUW  = 6'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } lane_state_e;

  function automatic logic op_is_div(input opcode_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_is_signed_div(input opcode_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic op_is_rem(input opcode_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_is_word(input opcode_t op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_ext_divider.sv
`default_nettype none
// ============================================================================
// m_ext_divider : iterative restoring divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
module m_ext_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_signed,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_trivial,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_q_init;
  logic            w_a_neg, w_b_neg, w_min, w_div_zero, w_overflow;
  logic [XLEN:0]   w_shift, w_diff;

  logic            r_busy, r_fix, r_negq, r_negr;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo, r_rem, r_div;

  // Word ops are widened to XLEN, and their magnitude is pre-shifted so the
  // 32 iterations consume exactly the low word.
  if (XLEN > 32) begin : g_wide
    assign w_a_ext  = !i_word ? i_dividend
                    : {{(XLEN-32){i_signed & i_dividend[31]}}, i_dividend[31:0]};
    assign w_b_ext  = !i_word ? i_divisor
                    : {{(XLEN-32){i_signed & i_divisor[31]}}, i_divisor[31:0]};
    assign w_min    = i_word ? (i_dividend[31:0] == 32'h8000_0000)
                             : (i_dividend == {1'b1, {(XLEN-1){1'b0}}});
    assign w_q_init = i_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
  end else begin : g_narrow
    assign w_a_ext  = i_dividend;
    assign w_b_ext  = i_divisor;
    assign w_min    = (i_dividend == {1'b1, {(XLEN-1){1'b0}}});
    assign w_q_init = w_a_mag;
  end

  assign w_a_neg    = i_signed & w_a_ext[XLEN-1];
  assign w_b_neg    = i_signed & w_b_ext[XLEN-1];
  assign w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_div_zero = (w_b_ext == '0);
  assign w_overflow = i_signed & w_min & (&w_b_ext);
  assign o_trivial  = w_div_zero | w_overflow;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_fix  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_fix  <= 1'b0;
    end else if (i_start) begin
      r_div <= w_b_mag;
      r_cnt <= i_word ? CW'(32) : CW'(XLEN);
      if (o_trivial) begin
        r_busy <= 1'b0;
        r_fix  <= 1'b1;
        r_negq <= 1'b0;
        r_negr <= 1'b0;
        r_quo  <= w_div_zero ? '1 : w_a_ext;
        r_rem  <= w_div_zero ? w_a_ext : '0;
      end else begin
        r_busy <= 1'b1;
        r_fix  <= 1'b0;
        r_negq <= w_a_neg ^ w_b_neg;
        r_negr <= w_a_neg;
        r_quo  <= w_q_init;
        r_rem  <= '0;
      end
    end else if (r_busy) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_fix  <= 1'b1;
      end
    end else if (r_fix) begin
      r_fix <= 1'b0;
    end
  end

  assign o_busy      = r_busy | r_fix;
  assign o_done      = r_fix;
  assign o_quotient  = r_negq ? -r_quo : r_quo;
  assign o_remainder = r_negr ? -r_rem : r_rem;

endmodule
`default_nettype wire

// File: rtl/m_ext_lane.sv
`default_nettype none
// ============================================================================
// m_ext_lane : RISC-V M-extension execution lane, one op in flight
// Rev 1.0
// ============================================================================
module m_ext_lane
  import m_ext_pkg::*;
#(
  parameter int XLEN                = 64,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 6
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  output logic                           dispatch_ready_o,
  input  logic                           dispatch_valid_i,
  input  logic [XLEN-1:0]                dispatch_1st_reg_i,
  input  logic [XLEN-1:0]                dispatch_2nd_reg_i,
  input  logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction_i,
  input  logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index_i,
  input  logic                           execute_ready_i,
  output logic                           execute_valid_o,
  output logic [ROB_INDEX_WIDTH-1:0]     execute_ROB_index_o,
  output logic [XLEN-1:0]                execute_value_o,
  input  logic                           flush_i
);

  lane_state_e                r_state;
  opcode_t                    r_op;
  logic [XLEN-1:0]            r_a, r_b;
  logic [ROB_INDEX_WIDTH-1:0] r_tag;

  opcode_t         w_disp_op;
  logic            w_accept, w_div_start, w_div_trivial, w_div_busy, w_div_done;
  logic [XLEN-1:0] w_quo, w_rem;
  logic            w_a_sgn, w_b_sgn, w_word;
  logic [XLEN:0]   w_ma, w_mb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_mul_res, w_raw, w_result;

  assign w_disp_op        = opcode_t'(dispatch_decoded_instruction_i);
  assign dispatch_ready_o = (r_state == ST_IDLE);
  assign w_accept         = dispatch_valid_i & dispatch_ready_o & ~flush_i;
  assign w_div_start      = w_accept & op_is_div(w_disp_op);

  m_ext_divider #(
    .XLEN (XLEN)
  ) u_div (
    .clk         (clock_i),
    .rst         (reset_i),
    .i_start     (w_div_start),
    .i_abort     (flush_i),
    .i_signed    (op_is_signed_div(w_disp_op)),
    .i_word      (op_is_word(w_disp_op) && (XLEN > 32)),
    .i_dividend  (dispatch_1st_reg_i),
    .i_divisor   (dispatch_2nd_reg_i),
    .o_trivial   (w_div_trivial),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // One (XLEN+1)-bit signed multiply covers all three signedness variants.
  assign w_a_sgn = (r_op == OP_MULH) || (r_op == OP_MULHSU);
  assign w_b_sgn = (r_op == OP_MULH);
  assign w_ma    = {w_a_sgn & r_a[XLEN-1], r_a};
  assign w_mb    = {w_b_sgn & r_b[XLEN-1], r_b};
  assign w_prod  = {{(XLEN-1){w_ma[XLEN]}}, w_ma} * {{(XLEN-1){w_mb[XLEN]}}, w_mb};

  always_comb begin
    w_mul_res = '0;
    case (r_op)
      OP_MUL, OP_MULW:              w_mul_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_mul_res = w_prod[2*XLEN-1:XLEN];
      default:                      w_mul_res = '0;
    endcase
  end

  assign w_word = op_is_word(r_op) && (XLEN > 32);
  assign w_raw  = op_is_div(r_op) ? (op_is_rem(r_op) ? w_rem : w_quo) : w_mul_res;

  if (XLEN > 32) begin : g_wsext
    assign w_result = w_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
  end else begin : g_nosext
    assign w_result = w_raw;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state             <= ST_IDLE;
      r_op                <= '0;
      r_a                 <= '0;
      r_b                 <= '0;
      r_tag               <= '0;
      execute_valid_o     <= 1'b0;
      execute_ROB_index_o <= '0;
      execute_value_o     <= '0;
    end else if (flush_i) begin
      r_state         <= ST_IDLE;
      execute_valid_o <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_disp_op;
            r_a     <= dispatch_1st_reg_i;
            r_b     <= dispatch_2nd_reg_i;
            r_tag   <= dispatch_ROB_index_i;
            r_state <= (op_is_div(w_disp_op) && !w_div_trivial) ? ST_DIV : ST_MUL;
          end
        end
        // Trivial divides also land here; the divider has their result ready.
        ST_MUL: begin
          execute_value_o     <= w_result;
          execute_ROB_index_o <= r_tag;
          execute_valid_o     <= 1'b1;
          r_state             <= ST_DONE;
        end
        ST_DIV: begin
          if (w_div_done) begin
            execute_value_o     <= w_result;
            execute_ROB_index_o <= r_tag;
            execute_valid_o     <= 1'b1;
            r_state             <= ST_DONE;
          end else if (!w_div_busy) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (execute_ready_i) begin
            execute_valid_o <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_ext_lane.sv
`default_nettype none
// ============================================================================
// tb_m_ext_lane : directed-vector bench for the M-extension lane
// Rev 1.0
// ============================================================================
module tb_m_ext_lane;

  logic        clk;
  logic        rst;
  logic        dispatch_ready_o;
  logic        dispatch_valid_i;
  logic [63:0] dispatch_1st_reg_i;
  logic [63:0] dispatch_2nd_reg_i;
  logic [5:0]  dispatch_decoded_instruction_i;
  logic [7:0]  dispatch_ROB_index_i;
  logic        execute_ready_i;
  logic        execute_valid_o;
  logic [7:0]  execute_ROB_index_o;
  logic [63:0] execute_value_o;
  logic        flush_i;

  int n_vec;
  int n_err;

  m_ext_lane #(
    .XLEN                (64),
    .ROB_INDEX_WIDTH     (8),
    .DECODED_INSTR_WIDTH (6)
  ) dut (
    .clock_i                        (clk),
    .reset_i                        (rst),
    .dispatch_ready_o               (dispatch_ready_o),
    .dispatch_valid_i               (dispatch_valid_i),
    .dispatch_1st_reg_i             (dispatch_1st_reg_i),
    .dispatch_2nd_reg_i             (dispatch_2nd_reg_i),
    .dispatch_decoded_instruction_i (dispatch_decoded_instruction_i),
    .dispatch_ROB_index_i           (dispatch_ROB_index_i),
    .execute_ready_i                (execute_ready_i),
    .execute_valid_o                (execute_valid_o),
    .execute_ROB_index_o            (execute_ROB_index_o),
    .execute_value_o                (execute_value_o),
    .flush_i                        (flush_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [7:0] tag);
    dispatch_valid_i               = 1'b1;
    dispatch_decoded_instruction_i = op;
    dispatch_1st_reg_i             = a;
    dispatch_2nd_reg_i             = b;
    dispatch_ROB_index_i           = tag;
    tick();
    dispatch_valid_i = 1'b0;
  endtask

  // Latency counts edges with the accepting edge as edge 1.
  task automatic run_vec(input string name, input logic [5:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input logic [7:0] tag);
    int n;
    n = 0;
    while (!dispatch_ready_o && n < 200) begin
      tick();
      n++;
    end
    check_vec({name, "/rdy"}, 64'(dispatch_ready_o), 64'd1);
    issue(op, a, b, tag);
    n = 1;
    while (!execute_valid_o && n < 200) begin
      tick();
      n++;
    end
    check_vec({name, "/lat"}, 64'(n), 64'(lat));
    check_vec({name, "/val"}, execute_value_o, exp);
    check_vec({name, "/tag"}, 64'(execute_ROB_index_o), 64'(tag));
    repeat (2) tick();
    check_vec({name, "/hold"}, {63'd0, execute_valid_o}, 64'd1);
    check_vec({name, "/holdv"}, execute_value_o, exp);
    execute_ready_i = 1'b1;
    tick();
    execute_ready_i = 1'b0;
    check_vec({name, "/rel"}, {62'd0, execute_valid_o, dispatch_ready_o}, 64'd1);
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;
    rst                            = 1'b1;
    flush_i                        = 1'b1;
    dispatch_valid_i               = 1'b0;
    dispatch_1st_reg_i             = '0;
    dispatch_2nd_reg_i             = '0;
    dispatch_decoded_instruction_i = '0;
    dispatch_ROB_index_i           = '0;
    execute_ready_i                = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_vec("rst/ready", 64'(dispatch_ready_o), 64'd1);
    check_vec("rst/valid", 64'(execute_valid_o), 64'd0);
    check_vec("rst/value", execute_value_o, 64'd0);
    check_vec("rst/tag", 64'(execute_ROB_index_o), 64'd0);

    // dispatch during flush must be ignored
    dispatch_valid_i               = 1'b1;
    dispatch_decoded_instruction_i = 6'd0;
    tick();
    dispatch_valid_i = 1'b0;
    flush_i          = 1'b0;
    tick();
    check_vec("flushdisp/ready", 64'(dispatch_ready_o), 64'd1);
    check_vec("flushdisp/valid", 64'(execute_valid_o), 64'd0);

    run_vec("mul",    6'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 2, 8'h15);
    run_vec("mulhu",  6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 2, 8'h21);
    run_vec("mulh",   6'd1, -64'sd1, -64'sd1, 64'd0, 2, 8'h22);
    run_vec("mulhsu", 6'd2, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2, 8'h23);
    run_vec("mulw",   6'd8, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 8'h24);
    run_vec("badop",  6'd13, 64'd9, 64'd9, 64'd0, 2, 8'h25);
    run_vec("div",    6'd4, -64'sd7, 64'd2, -64'sd3, 66, 8'h30);
    run_vec("rem",    6'd6, -64'sd7, 64'd2, -64'sd1, 66, 8'h31);
    run_vec("divu",   6'd5, 64'd100, 64'd7, 64'd14, 66, 8'h32);
    run_vec("remu",   6'd7, 64'd100, 64'd7, 64'd2, 66, 8'h33);
    run_vec("divuw",  6'd10, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 34, 8'h34);
    run_vec("remw",   6'd11, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 8'h35);
    run_vec("div0",   6'd4, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 8'h40);
    run_vec("rem0",   6'd6, 64'd5, 64'd0, 64'd5, 2, 8'h41);
    run_vec("divovf", 6'd4, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 2, 8'h42);
    run_vec("removf", 6'd6, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 2, 8'h43);
    run_vec("divwovf", 6'd9, 64'h1_8000_0000, -64'sd1, 64'hFFFF_FFFF_8000_0000, 2, 8'h44);

    // flush at cycle 10 of a divide: no result may ever appear
    issue(6'd5, 64'd1000, 64'd3, 8'h50);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_vec("flushdiv/valid", 64'(execute_valid_o), 64'd0);
    check_vec("flushdiv/ready", 64'(dispatch_ready_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (execute_valid_o) seen++;
    end
    check_vec("flushdiv/stale", 64'(seen), 64'd0);

    // flush while DONE is being held off by execute_ready_i=0
    issue(6'd0, 64'd6, 64'd7, 8'h60);
    tick();
    check_vec("flushdone/pre", 64'(execute_valid_o), 64'd1);
    check_vec("flushdone/preval", execute_value_o, 64'd42);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_vec("flushdone/valid", 64'(execute_valid_o), 64'd0);
    check_vec("flushdone/ready", 64'(dispatch_ready_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (execute_valid_o) seen++;
    end
    check_vec("flushdone/stale", 64'(seen), 64'd0);

    // lane still works after flushes
    run_vec("postflush", 6'd4, 64'd1000, -64'sd3, -64'sd333, 66, 8'h70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
